// File: rtl/nibble_packer_if.sv
// rtl/nibble_packer_if.sv - nibble input stream and packed-word output stream
interface nibble_packer_if #(
  parameter int NIBBLES = 4
);
  logic                   s_valid_i;
  logic                   s_ready_o;
  logic [3:0]             s_data_i;
  logic                   s_last_i;
  logic                   m_valid_o;
  logic                   m_ready_i;
  logic [4*NIBBLES-1:0]   m_data_o;
  logic [NIBBLES-1:0]     m_keep_o;
  logic                   m_last_o;

  modport slave (
    input  s_valid_i, s_data_i, s_last_i, m_ready_i,
    output s_ready_o, m_valid_o, m_data_o, m_keep_o, m_last_o
  );

  modport master (
    output s_valid_i, s_data_i, s_last_i, m_ready_i,
    input  s_ready_o, m_valid_o, m_data_o, m_keep_o, m_last_o
  );
endinterface

// File: rtl/nibble_packer.sv
// rtl/nibble_packer.sv - packs NIBBLES 4-bit beats into one word, last flushes early
module nibble_packer #(
  parameter int NIBBLES = 4
) (
  input  logic             clk,
  input  logic             rstn,
  nibble_packer_if.slave   bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);

  logic [W-1:0]       acc, nxt_data, out_data;
  logic [NIBBLES-1:0] acc_keep, nxt_keep, out_keep;
  logic               acc_last, acc_full, out_last, out_valid;
  logic [CW-1:0]      cnt;
  logic               accept, closing, out_free;

  assign bus.s_ready_o = ~acc_full;
  assign bus.m_valid_o = out_valid;
  assign bus.m_data_o  = out_data;
  assign bus.m_keep_o  = out_keep;
  assign bus.m_last_o  = out_last;

  assign out_free = ~out_valid | bus.m_ready_i;
  assign accept   = bus.s_valid_i & ~acc_full;
  assign closing  = accept & ((cnt == CW'(NIBBLES - 1)) | bus.s_last_i);

  // Word as it looks with the current beat merged into slot cnt
  always_comb begin
    nxt_data = acc;
    nxt_keep = acc_keep;
    nxt_data[4*cnt +: 4] = bus.s_data_i;
    nxt_keep[cnt]        = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc       <= '0;
      acc_keep  <= '0;
      acc_last  <= 1'b0;
      acc_full  <= 1'b0;
      cnt       <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (closing && out_free) begin
        out_data  <= nxt_data;
        out_keep  <= nxt_keep;
        out_last  <= bus.s_last_i;
        out_valid <= 1'b1;
        acc       <= '0;
        acc_keep  <= '0;
        acc_last  <= 1'b0;
      end else if (acc_full && out_free) begin
        out_data  <= acc;
        out_keep  <= acc_keep;
        out_last  <= acc_last;
        out_valid <= 1'b1;
        acc       <= '0;
        acc_keep  <= '0;
        acc_last  <= 1'b0;
        acc_full  <= 1'b0;
      end else if (bus.m_ready_i) begin
        out_valid <= 1'b0;
      end

      // accept implies acc_full == 0, so these updates never collide with the drain above
      if (accept) begin
        if (closing) begin
          cnt <= '0;
          if (!out_free) begin
            acc      <= nxt_data;
            acc_keep <= nxt_keep;
            acc_last <= bus.s_last_i;
            acc_full <= 1'b1;
          end
        end else begin
          cnt      <= cnt + 1'b1;
          acc      <= nxt_data;
          acc_keep <= nxt_keep;
        end
      end
    end
  end
endmodule

// File: tb/tb_nibble_packer.sv
// tb/tb_nibble_packer.sv - directed and random checks of nibble_packer against a word-queue model
module tb_nibble_packer;
  localparam int N = 4;
  localparam int W = 4 * N;

  typedef struct {
    logic [W-1:0] data;
    logic [N-1:0] keep;
    logic         last;
  } word_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  word_t exp_q[$];
  int    part[$];
  logic  prev_stall = 1'b0;
  word_t prev_w;

  nibble_packer_if #(.NIBBLES(N)) bus();
  nibble_packer #(.NIBBLES(N)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Collected nibbles become one word: nibble i lands at bits [4i+3:4i]
  task automatic close_word(input logic last);
    word_t w;
    w.data = '0;
    w.keep = '0;
    foreach (part[i]) begin
      w.data = w.data | (W'(part[i]) << (4 * i));
      w.keep[i] = 1'b1;
    end
    w.last = last;
    exp_q.push_back(w);
    part.delete();
  endtask

  task automatic step();
    word_t got, e;
    @(negedge clk);
    if (!rstn) begin
      exp_q.delete();
      part.delete();
      prev_stall = 1'b0;
    end else begin
      got.data = bus.m_data_o;
      got.keep = bus.m_keep_o;
      got.last = bus.m_last_o;
      if (prev_stall) begin
        chk("stall_valid", 64'(bus.m_valid_o), 64'h1);
        chk("stall_data", 64'(got.data), 64'(prev_w.data));
        chk("stall_keep", 64'(got.keep), 64'(prev_w.keep));
        chk("stall_last", 64'(got.last), 64'(prev_w.last));
      end
      // closed-but-undelivered words can number at most two (out register + acc)
      chk("ready_model", 64'(bus.s_ready_o), 64'(exp_q.size() < 2));
      chk("valid_model", 64'(bus.m_valid_o), 64'(exp_q.size() > 0));
      if (bus.m_valid_o && bus.m_ready_i) begin
        chk("word_expected", 64'(exp_q.size() > 0), 64'h1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("word_data", 64'(got.data), 64'(e.data));
          chk("word_keep", 64'(got.keep), 64'(e.keep));
          chk("word_last", 64'(got.last), 64'(e.last));
        end
      end
      if (bus.s_valid_i && bus.s_ready_o) begin
        part.push_back(int'(bus.s_data_i));
        if (part.size() == N || bus.s_last_i) close_word(bus.s_last_i);
      end
      prev_stall = bus.m_valid_o && !bus.m_ready_i;
      prev_w = got;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic last);
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = d;
    bus.s_last_i  = last;
    step();
    bus.s_valid_i = 1'b0;
    bus.s_last_i  = 1'b0;
  endtask

  initial begin
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = 4'h0;
    bus.s_last_i  = 1'b0;
    bus.m_ready_i = 1'b0;

    step();
    step();
    chk("rst_valid", 64'(bus.m_valid_o), 64'h0);
    chk("rst_data", 64'(bus.m_data_o), 64'h0);
    chk("rst_keep", 64'(bus.m_keep_o), 64'h0);
    chk("rst_last", 64'(bus.m_last_o), 64'h0);
    chk("rst_ready", 64'(bus.s_ready_o), 64'h1);
    rstn = 1'b1;
    bus.m_ready_i = 1'b1;

    for (int k = 1; k <= 4; k++) send(4'(k), 1'b0);
    chk("full_valid", 64'(bus.m_valid_o), 64'h1);
    chk("full_data", 64'(bus.m_data_o), 64'h4321);
    chk("full_keep", 64'(bus.m_keep_o), 64'hF);
    chk("full_last", 64'(bus.m_last_o), 64'h0);
    step();
    chk("full_pulse", 64'(bus.m_valid_o), 64'h0);

    send(4'hA, 1'b0);
    send(4'hB, 1'b1);
    chk("flush_valid", 64'(bus.m_valid_o), 64'h1);
    chk("flush_data", 64'(bus.m_data_o), 64'h00BA);
    chk("flush_keep", 64'(bus.m_keep_o), 64'h3);
    chk("flush_last", 64'(bus.m_last_o), 64'h1);
    for (int k = 5; k <= 8; k++) send(4'(k), 1'b0);
    chk("after_flush_data", 64'(bus.m_data_o), 64'h8765);
    chk("after_flush_keep", 64'(bus.m_keep_o), 64'hF);
    chk("after_flush_last", 64'(bus.m_last_o), 64'h0);
    step();

    bus.m_ready_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      send(4'(k), 1'b0);
      if (k >= 4) chk("bp_hold", 64'(bus.m_data_o), 64'h4321);
    end
    chk("bp_ready_low", 64'(bus.s_ready_o), 64'h0);
    step();
    step();
    chk("bp_hold_late", 64'(bus.m_data_o), 64'h4321);
    chk("bp_ready_still_low", 64'(bus.s_ready_o), 64'h0);
    bus.m_ready_i = 1'b1;
    step();
    chk("bp_second_valid", 64'(bus.m_valid_o), 64'h1);
    chk("bp_second_data", 64'(bus.m_data_o), 64'h8765);
    chk("bp_ready_back", 64'(bus.s_ready_o), 64'h1);
    step();
    chk("bp_drained", 64'(bus.m_valid_o), 64'h0);

    send(4'h9, 1'b0);
    send(4'hA, 1'b0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int k = 1; k <= 4; k++) send(4'(k), 1'b0);
    chk("midrst_data", 64'(bus.m_data_o), 64'h4321);
    chk("midrst_keep", 64'(bus.m_keep_o), 64'hF);
    chk("midrst_last", 64'(bus.m_last_o), 64'h0);
    step();
    chk("midrst_single", 64'(bus.m_valid_o), 64'h0);
    chk("midrst_queue", 64'(exp_q.size()), 64'h0);

    for (int c = 0; c < 2000; c++) begin
      bus.s_valid_i = ($urandom % 4) != 0;
      bus.s_data_i  = 4'($urandom);
      bus.s_last_i  = ($urandom % 5) == 0;
      bus.m_ready_i = ($urandom % 3) != 0;
      step();
    end
    bus.s_valid_i = 1'b0;
    bus.s_last_i  = 1'b0;
    bus.m_ready_i = 1'b1;
    repeat (4) step();
    chk("drain_empty", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
